// File: rtl/matrix_pkg.sv
// Shared constants for the 2x2 matrix sequencer: opcodes, element indices,
// per-op cycle counts and FSM state encoding.
package matrix_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DET = 3'd3;
   localparam logic [2:0] OP_TRP = 3'd4;

   // Element index = {row, col}, row-major, matching the packed matrix order
   localparam logic [1:0] IDX_11 = 2'd0;
   localparam logic [1:0] IDX_12 = 2'd1;
   localparam logic [1:0] IDX_21 = 2'd2;
   localparam logic [1:0] IDX_22 = 2'd3;

   localparam int N_CYC_4   = 4;
   localparam int N_CYC_DET = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } seq_state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_TRP;
   endfunction

endpackage

// File: rtl/matrix_op_sequencer_mac2.sv
// Combinational two-product MAC: res = x*y +/- u*v.
// Operands are zero-extended; the arithmetic wraps at RES_W bits.
module mac2 #(
   parameter int ELEM_W = 3,
   parameter int RES_W  = 8
) (
   input  logic [ELEM_W-1:0]       x,
   input  logic [ELEM_W-1:0]       y,
   input  logic [ELEM_W-1:0]       u,
   input  logic [ELEM_W-1:0]       v,
   input  logic                    sub,
   output logic signed [RES_W-1:0] res
);

   logic [RES_W-1:0] p_xy;
   logic [RES_W-1:0] p_uv;

   assign p_xy = RES_W'(x) * RES_W'(y);
   assign p_uv = RES_W'(u) * RES_W'(v);
   assign res  = sub ? signed'(p_xy - p_uv) : signed'(p_xy + p_uv);

endmodule

// File: rtl/matrix_op_sequencer.sv
// Time-shared 2x2 matrix op sequencer: one result element per cycle through a
// single mac2, operands and result held in registers across the handshake.
//
//   state  | meaning
//   IDLE   | waiting for a request, in_ready=1
//   RUN    | one element per cycle, cnt_q counts down remaining elements
//   DONE   | result presented, waiting for out_ready
module matrix_op_sequencer
   import matrix_pkg::*;
#(
   parameter int ELEM_W = 3,
   parameter int RES_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [4*ELEM_W-1:0]   a_mat,
   input  logic [4*ELEM_W-1:0]   b_mat,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*RES_W-1:0]    c_mat,
   output logic                  err,
   output logic                  busy
);

   localparam logic [ELEM_W-1:0] ONE  = ELEM_W'(1);
   localparam logic [ELEM_W-1:0] ZERO = '0;

   seq_state_t state_q, state_d;
   logic [2:0]          op_q;
   logic [4*ELEM_W-1:0] a_q, b_q;
   logic [1:0]          idx_q;
   logic [1:0]          cnt_q;
   logic [4*RES_W-1:0]  c_q;
   logic                err_q;
   logic                accept;

   logic [ELEM_W-1:0]       mac_x, mac_y, mac_u, mac_v;
   logic                    mac_sub;
   logic signed [RES_W-1:0] mac_res;

   function automatic logic [ELEM_W-1:0] elem(input logic [4*ELEM_W-1:0] m,
                                              input logic [1:0] k);
      return m[(3-k)*ELEM_W +: ELEM_W];
   endfunction

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = op_legal(op) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt_q == 2'd0) state_d = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operand mux: idx_q = {i, j}; ADD is the default routing
   always_comb begin
      mac_x   = elem(a_q, idx_q);
      mac_y   = ONE;
      mac_u   = elem(b_q, idx_q);
      mac_v   = ONE;
      mac_sub = 1'b0;
      case (op_q)
         OP_SUB: mac_sub = 1'b1;
         OP_MUL: begin
            mac_x = elem(a_q, {idx_q[1], 1'b0});
            mac_y = elem(b_q, {1'b0, idx_q[0]});
            mac_u = elem(a_q, {idx_q[1], 1'b1});
            mac_v = elem(b_q, {1'b1, idx_q[0]});
         end
         OP_DET: begin
            mac_x   = elem(a_q, IDX_11);
            mac_y   = elem(a_q, IDX_22);
            mac_u   = elem(a_q, IDX_12);
            mac_v   = elem(a_q, IDX_21);
            mac_sub = 1'b1;
         end
         OP_TRP: begin
            mac_x = elem(a_q, {idx_q[0], idx_q[1]});
            mac_u = ZERO;
            mac_v = ZERO;
         end
         default: ;
      endcase
   end

   mac2 #(.ELEM_W(ELEM_W), .RES_W(RES_W)) u_mac2 (
      .x   (mac_x),
      .y   (mac_y),
      .u   (mac_u),
      .v   (mac_v),
      .sub (mac_sub),
      .res (mac_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         c_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= op;
            a_q   <= a_mat;
            b_q   <= b_mat;
            idx_q <= '0;
            cnt_q <= (op == OP_DET) ? 2'(N_CYC_DET - 1) : 2'(N_CYC_4 - 1);
            c_q   <= '0;
            err_q <= ~op_legal(op);
         end else if (state_q == S_RUN) begin
            c_q[(3-idx_q)*RES_W +: RES_W] <= mac_res;
            idx_q <= idx_q + 2'd1;
            cnt_q <= cnt_q - 2'd1;
         end
      end
   end

   assign c_mat = c_q;
   assign err   = err_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed-vector bench for matrix_op_sequencer (ELEM_W=3, RES_W=8).
// Latency is counted in clock edges after the accept edge.
module tb_matrix_op_sequencer;

   localparam int ELEM_W = 3;
   localparam int RES_W  = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [2:0]          op;
   logic [4*ELEM_W-1:0] a_mat;
   logic [4*ELEM_W-1:0] b_mat;
   logic                out_valid;
   logic                out_ready;
   logic [4*RES_W-1:0]  c_mat;
   logic                err;
   logic                busy;

   int n_checks = 0;
   int n_pass   = 0;

   matrix_op_sequencer #(.ELEM_W(ELEM_W), .RES_W(RES_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a_mat     (a_mat),
      .b_mat     (b_mat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c_mat     (c_mat),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [4*ELEM_W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
      return {3'(e0), 3'(e1), 3'(e2), 3'(e3)};
   endfunction

   task automatic start_op(input logic [2:0] o, input logic [11:0] a, input logic [11:0] b);
      check("in_ready_before", in_ready, 1);
      in_valid = 1'b1;
      op       = o;
      a_mat    = a;
      b_mat    = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_mat    = '1;
      b_mat    = '1;
      op       = 3'd7;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("out_valid_timeout", out_valid, 1);
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [11:0] a,
                         input logic [11:0] b, input logic [31:0] exp_c,
                         input logic exp_err, input int exp_lat);
      int lat;
      start_op(o, a, b);
      wait_done(lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_c"}, c_mat, exp_c);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_busy"}, busy, 1);
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_rdy_after"}, in_ready, 1);
   endtask

   initial begin
      int lat;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 3'd0;
      a_mat     = '0;
      b_mat     = '0;
      out_ready = 1'b1;
      #22;
      check("rst_out_valid", out_valid, 0);
      check("rst_c", c_mat, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);

      run_op("add", 3'd0, pk(1,2,3,4), pk(7,7,7,7), 32'h08090A0B, 1'b0, 4);
      run_op("sub", 3'd1, pk(0,7,3,5), pk(7,0,3,6), 32'hF90700FF, 1'b0, 4);
      run_op("mul", 3'd2, pk(1,2,3,4), pk(5,6,7,0), 32'h13062B12, 1'b0, 4);
      run_op("det", 3'd3, pk(3,5,2,7), pk(7,7,7,7), 32'h0B000000, 1'b0, 1);
      run_op("trp", 3'd4, pk(1,2,3,4), pk(7,7,7,7), 32'h01030204, 1'b0, 4);
      // illegal op goes straight to DONE on the accept edge
      run_op("ill", 3'd6, pk(1,2,3,4), pk(5,6,7,0), 32'h00000000, 1'b1, 0);
      run_op("legal_after_ill", 3'd0, pk(0,0,7,7), pk(0,1,0,7), 32'h0001070E, 1'b0, 4);

      // backpressure with a pending request held high
      out_ready = 1'b0;
      start_op(3'd2, pk(1,2,3,4), pk(5,6,7,0));
      wait_done(lat);
      check("bp_lat", lat, 4);
      in_valid = 1'b1;
      op       = 3'd0;
      a_mat    = pk(1,2,3,4);
      b_mat    = pk(7,7,7,7);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("bp_valid_hold", out_valid, 1);
         check("bp_c_hold", c_mat, 32'h13062B12);
         check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_drop", out_valid, 0);
      check("bp_ready_rise", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_accept_busy", busy, 1);
      wait_done(lat);
      check("bp_next_lat", lat, 4);
      check("bp_next_c", c_mat, 32'h08090A0B);
      @(posedge clk); #1;

      // async reset during MUL at idx=2
      start_op(3'd2, pk(1,2,3,4), pk(5,6,7,0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_busy", busy, 1);
      check("mid_partial_c", c_mat, 32'h13060000);
      rst = 1'b1;
      #1;
      check("async_c", c_mat, 0);
      check("async_busy", busy, 0);
      check("async_valid", out_valid, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", in_ready, 1);
      check("post_rst_valid", out_valid, 0);
      run_op("add_after_rst", 3'd0, pk(1,2,3,4), pk(7,7,7,7), 32'h08090A0B, 1'b0, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
